// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave front-end: command codes, FSM
// state encoding and a small elaboration-time helper.
package spi_slave_pkg;

  // Two-bit command field, first two bits of every frame.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Frame-level controller states, sequentially encoded.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Larger of two widths; used to size the payload.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// Parallel-load, MSB-first shift-out for MISO. The MSB appears right
// after the load edge, the LSB DATA_W-1 edges later, and the line
// returns to 0 on the following edge.
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              abort,
  output logic              miso,
  output logic              busy
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] sh_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;

  // Shift register: load, shift left while bits remain, clear when done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load) begin
      sh_q   <= data;
      cnt_q  <= CW'(DATA_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        sh_q   <= '0;
        busy_q <= 1'b0;
      end else begin
        sh_q  <= sh_q << 1;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // The register top bit is the line itself, so MISO is glitch-free and
  // is 0 whenever nothing is being shifted.
  assign miso = sh_q[DATA_W-1];
  assign busy = busy_q;

endmodule

// File: rtl/spi_slave_gen.sv
// SPI slave front-end for the single-port RAM subsystem. Deserialises a
// {cmd, payload} frame into rx_data with a one-cycle rx_valid strobe; for
// read-data commands waits (bounded) for tx_valid and serialises tx_data
// onto MISO. ss_n high outside IDLE aborts the frame silently.
module spi_slave_gen
  import spi_slave_pkg::*;
#(
  parameter int  ADDR_W     = 8,
  parameter int  DATA_W     = 8,
  parameter int  TX_TIMEOUT = 15,
  localparam int PAY_W      = max_int(ADDR_W, DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [PAY_W+1:0]   rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               err
);

  localparam int FRAME_W = PAY_W + 2;
  localparam int CNT_W   = $clog2(PAY_W + 3);
  localparam int WAIT_W  = $clog2(TX_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-2:0] sh_q, sh_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               err_q, err_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic [FRAME_W-1:0] frame;
  logic [1:0]         cmd;
  logic               abort;
  logic               tx_load;
  logic               tx_busy;

  // The completed frame is the stored bits plus the bit on the wire now.
  assign frame = {sh_q, mosi};
  assign cmd   = frame[FRAME_W-1 -: 2];
  assign abort = (state_q != ST_IDLE) && ss_n;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sh_q           <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      err_q          <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      wait_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sh_q           <= sh_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      err_q          <= err_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      wait_q         <= wait_d;
    end
  end

  // Next-state logic: frame reception, command decode, read-data wait.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sh_d           = sh_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    err_d          = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    wait_d         = wait_q;
    tx_load        = 1'b0;

    if (abort) begin
      // rx_data deliberately holds its last value across an abort.
      state_d = ST_IDLE;
      cnt_d   = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!ss_n) begin
            sh_d    = {sh_q[FRAME_W-3:0], mosi};
            cnt_d   = CNT_W'(1);
            state_d = ST_RX;
          end
        end
        ST_RX: begin
          if (cnt_q == CNT_W'(FRAME_W - 1)) begin
            cnt_d  = '0;
            wait_d = '0;
            if (cmd == CMD_RD_DATA && !rd_addr_seen_q) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              rx_data_d  = frame;
              rx_valid_d = 1'b1;
              if (cmd == CMD_RD_ADDR) begin
                rd_addr_seen_d = 1'b1;
              end
              state_d = (cmd == CMD_RD_DATA) ? ST_WAIT_TX : ST_DONE;
            end
          end else begin
            sh_d  = {sh_q[FRAME_W-3:0], mosi};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_TX: begin
          // tx_valid wins over a coincident timeout.
          if (tx_valid) begin
            tx_load = 1'b1;
            wait_d  = '0;
            state_d = ST_SHIFT;
          end else if (wait_q == WAIT_W'(TX_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            wait_d  = '0;
            state_d = ST_DONE;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_SHIFT: begin
          if (!tx_busy) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .data  (tx_data),
    .abort (abort),
    .miso  (miso),
    .busy  (tx_busy)
  );

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen. Two instances (8/8 with a 4-cycle timeout and
// 10/16 with the default timeout) share a clock. Directed frames are
// driven on the falling edge; a timeline model records, per rising-edge
// index, what each output must show, and one process compares every cycle.
module tb_spi_slave_gen;

  localparam int NCYC = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ss_n_a, mosi_a, tx_valid_a, miso_a, rx_valid_a, err_a;
  logic [7:0]  tx_data_a;
  logic [9:0]  rx_data_a;
  logic        ss_n_b, mosi_b, tx_valid_b, miso_b, rx_valid_b, err_b;
  logic [15:0] tx_data_b;
  logic [17:0] rx_data_b;

  spi_slave_gen #(.ADDR_W(8), .DATA_W(8), .TX_TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n_a), .mosi(mosi_a), .miso(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .err(err_a)
  );

  spi_slave_gen #(.ADDR_W(10), .DATA_W(16), .TX_TIMEOUT(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .ss_n(ss_n_b), .mosi(mosi_b), .miso(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .err(err_b)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // Expected outputs indexed by "cycle after rising edge number i-1".
  logic        exp_rv [2][NCYC];
  logic        exp_er [2][NCYC];
  logic        exp_mi [2][NCYC];
  logic [17:0] exp_rd [2][NCYC];
  logic [17:0] cur_rd [2];
  bit          seen   [2];
  int          rv_cnt [2];
  int          er_cnt [2];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  function automatic logic miso_of(input int d);
    return (d == 0) ? miso_a : miso_b;
  endfunction
  function automatic logic rv_of(input int d);
    return (d == 0) ? rx_valid_a : rx_valid_b;
  endfunction
  function automatic logic er_of(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction
  function automatic logic [17:0] rd_of(input int d);
    return (d == 0) ? {8'h00, rx_data_a} : rx_data_b;
  endfunction

  // Per-cycle comparison of both instances against the timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      if (edge_n >= NCYC) begin
        $display("FAIL cycle_budget: edge %0d beyond %0d", edge_n, NCYC);
        $fatal(1, "cycle budget exhausted");
      end
      for (int d = 0; d < 2; d++) begin
        if (exp_rv[d][edge_n]) cur_rd[d] = exp_rd[d][edge_n];
        chk($sformatf("rx_valid[%0d]", d), {17'h0, rv_of(d)},   {17'h0, exp_rv[d][edge_n]});
        chk($sformatf("err[%0d]", d),      {17'h0, er_of(d)},   {17'h0, exp_er[d][edge_n]});
        chk($sformatf("miso[%0d]", d),     {17'h0, miso_of(d)}, {17'h0, exp_mi[d][edge_n]});
        chk($sformatf("rx_data[%0d]", d),  rd_of(d), cur_rd[d]);
        rv_cnt[d] += int'(rv_of(d));
        er_cnt[d] += int'(er_of(d));
      end
    end
  end

  // Drive inputs for the coming rising edge, then wait past it.
  task automatic step(input int d, input logic ss, input logic mo, input logic tv,
                      input logic [15:0] td);
    if (d == 0) begin
      ss_n_a = ss; mosi_a = mo; tx_valid_a = tv; tx_data_a = td[7:0];
    end else begin
      ss_n_b = ss; mosi_b = mo; tx_valid_b = tv; tx_data_b = td;
    end
    @(negedge clk);
  endtask

  task automatic end_frame(input int d);
    step(d, 1'b1, 1'b0, 1'b0, 16'h0);
    step(d, 1'b1, 1'b0, 1'b0, 16'h0);
  endtask

  // Send one frame MSB first; abort_at >= 0 raises ss_n on that bit index.
  task automatic send_frame(input int d, input logic [17:0] fr, input int abort_at);
    int         n;
    int         e_last;
    logic [1:0] cmd;
    n      = (d == 0) ? 10 : 18;
    cmd    = fr[n-1 -: 2];
    e_last = edge_n + n - 1;
    if (abort_at < 0) begin
      if (cmd == 2'b11 && !seen[d]) begin
        exp_er[d][e_last+1] = 1'b1;
      end else begin
        exp_rv[d][e_last+1] = 1'b1;
        exp_rd[d][e_last+1] = fr;
        if (cmd == 2'b10) seen[d] = 1'b1;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        step(d, 1'b1, 1'b0, 1'b0, 16'h0);
        break;
      end
      step(d, 1'b0, fr[n-1-i], 1'b0, 16'h0);
    end
  endtask

  // Read-data phase: tx_valid offered on the j-th WAIT_TX edge (0-based).
  task automatic tx_phase(input int d, input int j, input logic [15:0] data,
                          output logic [15:0] got, output logic tail);
    int dw;
    int t;
    int k;
    dw = (d == 0) ? 8 : 16;
    t  = (d == 0) ? 4 : 15;
    k  = edge_n + j;
    if (j < t) begin
      for (int b = 0; b < dw; b++) exp_mi[d][k+1+b] = data[dw-1-b];
    end else begin
      exp_er[d][edge_n+t] = 1'b1;
    end
    for (int i = 0; i < j; i++) step(d, 1'b0, 1'b0, 1'b0, 16'h0);
    step(d, 1'b0, 1'b0, 1'b1, data);
    got = '0;
    for (int b = 0; b < dw; b++) begin
      got = {got[14:0], miso_of(d)};
      step(d, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    tail = miso_of(d);
    step(d, 1'b0, 1'b0, 1'b0, 16'h0);
    end_frame(d);
  endtask

  logic [15:0] got;
  logic        tail;

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCYC; i++) begin
        exp_rv[d][i] = 1'b0; exp_er[d][i] = 1'b0;
        exp_mi[d][i] = 1'b0; exp_rd[d][i] = '0;
      end
      cur_rd[d] = '0; seen[d] = 1'b0; rv_cnt[d] = 0; er_cnt[d] = 0;
    end
    ss_n_a = 1'b1; mosi_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0;
    ss_n_b = 1'b1; mosi_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;
    repeat (3) @(negedge clk);

    chk("reset_rx_data_a", {8'h0, rx_data_a}, 18'h0);
    chk("reset_flags_a", {15'h0, miso_a, rx_valid_a, err_a}, 18'h0);
    chk("reset_rx_data_b", rx_data_b, 18'h0);
    chk("reset_flags_b", {15'h0, miso_b, rx_valid_b, err_b}, 18'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Write address 00_3C: strobe exactly in the cycle after edge 9.
    send_frame(0, 18'h0003C, -1);
    chk("wa_rx_valid_now", {17'h0, rx_valid_a}, 18'h1);
    chk("wa_rx_data", {8'h0, rx_data_a}, 18'h0003C);
    end_frame(0);
    chk("wa_rx_valid_after", {17'h0, rx_valid_a}, 18'h0);

    // Read data before any read address: error, tx_valid in DONE ignored.
    send_frame(0, 18'h00300, -1);
    chk("rd_noaddr_err", {17'h0, err_a}, 18'h1);
    chk("rd_noaddr_rv", {17'h0, rx_valid_a}, 18'h0);
    repeat (3) step(0, 1'b0, 1'b0, 1'b1, 16'h00FF);
    end_frame(0);

    // Full read: 10_3C then 11_5A, tx_valid on the third WAIT_TX edge.
    send_frame(0, 18'h0023C, -1);
    end_frame(0);
    send_frame(0, 18'h0035A, -1);
    tx_phase(0, 2, 16'h00A5, got, tail);
    chk("read_miso_bits", {10'h0, got[7:0]}, 18'h000A5);
    chk("read_miso_tail", {17'h0, tail}, 18'h0);

    // Timeout: tx_valid arrives two edges after the 4-cycle window.
    send_frame(0, 18'h00300, -1);
    tx_phase(0, 6, 16'h00FF, got, tail);
    chk("timeout_miso_quiet", {2'b0, got}, 18'h0);

    // Abort at bit 5, then 01_FF decodes cleanly.
    send_frame(0, 18'h00077, 5);
    send_frame(0, 18'h001FF, -1);
    chk("abort_next_rx_data", {8'h0, rx_data_a}, 18'h001FF);
    end_frame(0);

    // Wide instance: 18-bit frames and a 16-bit readout.
    send_frame(1, 18'h20123, -1);
    chk("wide_rx_valid_now", {17'h0, rx_valid_b}, 18'h1);
    end_frame(1);
    send_frame(1, 18'h30000, -1);
    tx_phase(1, 0, 16'hBEEF, got, tail);
    chk("wide_miso_bits", {2'b0, got}, 18'h0BEEF);
    chk("wide_miso_tail", {17'h0, tail}, 18'h0);
    send_frame(1, 18'h1CAFE, -1);
    chk("wide_rx_data", rx_data_b, 18'h1CAFE);
    end_frame(1);

    chk("pulses_rv_a", 18'(rv_cnt[0]), 18'd5);
    chk("pulses_err_a", 18'(er_cnt[0]), 18'd2);
    chk("pulses_rv_b", 18'(rv_cnt[1]), 18'd3);
    chk("pulses_err_b", 18'(er_cnt[1]), 18'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
